// File: rtl/pio_pkg.sv
// Shared definitions for the pio core and its stream loader: action codes,
// strobe widths, frame byte offsets and the loader parser states.
// Optional feature macro: PIO_LOADER_CSUM_EN (adds a trailing XOR checksum byte).
package pio_pkg;

    localparam int ACTION_W = 4;
    localparam int INDEX_W  = 5;
    localparam int MINDEX_W = 2;
    localparam int DATA_W   = 32;

    localparam logic [ACTION_W-1:0] ACT_NONE  = 4'd0;
    localparam logic [ACTION_W-1:0] ACT_INSTR = 4'd1;
    localparam logic [ACTION_W-1:0] ACT_REG   = 4'd2;
    localparam logic [ACTION_W-1:0] ACT_CTRL  = 4'd3;

    // Byte offsets inside one loader frame
    localparam int OFS_CMD   = 0;
    localparam int OFS_IDX   = 1;
    localparam int OFS_DAT   = 2;
    localparam int DAT_BYTES = DATA_W / 8;
`ifdef PIO_LOADER_CSUM_EN
    localparam int OFS_CSUM  = OFS_DAT + DAT_BYTES;
    localparam int FRAME_LEN = OFS_CSUM + 1;
`else
    localparam int FRAME_LEN = OFS_DAT + DAT_BYTES;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IDX,
        ST_DAT,
        ST_ISSUE
`ifdef PIO_LOADER_CSUM_EN
        , ST_CSUM
`endif
    } loader_state_t;

endpackage

// File: rtl/pio_stream_loader.sv
// Byte-stream loader: parses fixed-length frames from a byte source into
// single-cycle pio write strobes (action/index/mindex/din).
// Optional feature macro: PIO_LOADER_CSUM_EN (frame carries B6 = XOR of B0..B5).
module pio_stream_loader
    import pio_pkg::*;
#(
    parameter int TIMEOUT = 2500000,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [ACTION_W-1:0] action,
    output logic [INDEX_W-1:0]  index,
    output logic [MINDEX_W-1:0] mindex,
    output logic [DATA_W-1:0]   din,
    output logic                err,
    output logic [CNT_W-1:0]    frame_cnt
);

    // Gap counter only needs to reach TIMEOUT-1; TIMEOUT==0 disables it.
    localparam int               GAP_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit               TO_EN    = (TIMEOUT != 0);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    loader_state_t       state_q, state_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [ACTION_W-1:0] act_sh_q, act_sh_d;
    logic [MINDEX_W-1:0] mindex_sh_q, mindex_sh_d;
    logic [INDEX_W-1:0]  index_sh_q, index_sh_d;
    logic [DATA_W-1:0]   data_sh_q, data_sh_d;
    logic [INDEX_W-1:0]  index_q, index_d;
    logic [MINDEX_W-1:0] mindex_q, mindex_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
`ifdef PIO_LOADER_CSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic                 accept;
    logic                 in_frame;
    logic                 timeout_hit;
    logic                 issue_go;
    logic [DAT_BYTES-1:0] lane_we;

    assign accept   = rx_valid & rx_ready;
    assign in_frame = (state_q == ST_IDX) || (state_q == ST_DAT)
`ifdef PIO_LOADER_CSUM_EN
                      || (state_q == ST_CSUM)
`endif
                      ;
    assign timeout_hit = TO_EN && in_frame && !accept && (gap_q == GAP_LAST);

    // Little-endian payload capture, one lane per data byte
    for (genvar gi = 0; gi < DAT_BYTES; gi++) begin : g_lane
        assign lane_we[gi] = accept && (state_q == ST_DAT) && (byte_cnt_q == 2'(gi));
        assign data_sh_d[gi*8 +: 8] = lane_we[gi] ? rx_data : data_sh_q[gi*8 +: 8];
    end

    // State register and all datapath flops
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= '0;
            act_sh_q    <= '0;
            mindex_sh_q <= '0;
            index_sh_q  <= '0;
            data_sh_q   <= '0;
            index_q     <= '0;
            mindex_q    <= '0;
            din_q       <= '0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
            gap_q       <= '0;
`ifdef PIO_LOADER_CSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            act_sh_q    <= act_sh_d;
            mindex_sh_q <= mindex_sh_d;
            index_sh_q  <= index_sh_d;
            data_sh_q   <= data_sh_d;
            index_q     <= index_d;
            mindex_q    <= mindex_d;
            din_q       <= din_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            gap_q       <= gap_d;
`ifdef PIO_LOADER_CSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    // Frame parser: next state, field capture, rejection and timeout handling
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        act_sh_d    = act_sh_q;
        mindex_sh_d = mindex_sh_q;
        index_sh_d  = index_sh_q;
        err_d       = 1'b0;
        issue_go    = 1'b0;
`ifdef PIO_LOADER_CSUM_EN
        csum_d      = csum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // A zero action code is the resync point: reject and stay here
                    if (rx_data[7:4] == ACT_NONE) begin
                        err_d = 1'b1;
                    end else begin
                        act_sh_d    = rx_data[7:4];
                        mindex_sh_d = rx_data[3:2];
                        state_d     = ST_IDX;
`ifdef PIO_LOADER_CSUM_EN
                        csum_d      = rx_data;
`endif
                    end
                end
            end
            ST_IDX: begin
                if (accept) begin
                    if (rx_data[7:5] != 3'b000) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        index_sh_d = rx_data[4:0];
                        byte_cnt_d = '0;
                        state_d    = ST_DAT;
`ifdef PIO_LOADER_CSUM_EN
                        csum_d     = csum_q ^ rx_data;
`endif
                    end
                end
            end
            ST_DAT: begin
                if (accept) begin
`ifdef PIO_LOADER_CSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    if (byte_cnt_q == 2'(DAT_BYTES - 1)) begin
`ifdef PIO_LOADER_CSUM_EN
                        state_d  = ST_CSUM;
`else
                        state_d  = ST_ISSUE;
                        issue_go = 1'b1;
`endif
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
`ifdef PIO_LOADER_CSUM_EN
            ST_CSUM: begin
                if (accept) begin
                    if (rx_data == csum_q) begin
                        state_d  = ST_ISSUE;
                        issue_go = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
`endif
            ST_ISSUE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (timeout_hit) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
        end

        // Inter-byte gap restarts on every accepted byte and only runs mid-frame
        if (!TO_EN || accept || !in_frame) begin
            gap_d = '0;
        end else begin
            gap_d = gap_q + 1'b1;
        end

        // Strobe fields load only for a frame that is actually issued
        index_d     = issue_go ? index_sh_q  : index_q;
        mindex_d    = issue_go ? mindex_sh_q : mindex_q;
        din_d       = issue_go ? data_sh_d   : din_q;
        frame_cnt_d = issue_go ? frame_cnt_q + 1'b1 : frame_cnt_q;
    end

    // Outputs: byte bubble and action strobe during the issue cycle
    always_comb begin
        rx_ready  = !reset && (state_q != ST_ISSUE);
        action    = (state_q == ST_ISSUE) ? act_sh_q : ACT_NONE;
        index     = index_q;
        mindex    = mindex_q;
        din       = din_q;
        err       = err_q;
        frame_cnt = frame_cnt_q;
    end

endmodule

// File: tb/tb_pio_stream_loader.sv
// Testbench for pio_stream_loader: directed frames plus a randomized frame
// mix checked against a frame-level reference model.
// Honours PIO_LOADER_CSUM_EN for the checksum byte and its directed case.
module tb_pio_stream_loader;
    import pio_pkg::*;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 4;
`ifdef PIO_LOADER_CSUM_EN
    localparam int FRAME_CYC = 8;
`else
    localparam int FRAME_CYC = 7;
`endif

    typedef struct {
        logic [3:0]  a;
        logic [4:0]  i;
        logic [1:0]  m;
        logic [31:0] d;
    } strobe_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [7:0]          rx_data = 8'h00;
    logic                rx_valid = 1'b0;
    logic                rx_ready;
    logic [ACTION_W-1:0] action;
    logic [INDEX_W-1:0]  index;
    logic [MINDEX_W-1:0] mindex;
    logic [DATA_W-1:0]   din;
    logic                err;
    logic [CNT_W-1:0]    frame_cnt;

    int total = 0;
    int passed = 0;
    int fails = 0;
    int cyc = 0;
    int strobes = 0;
    int errs = 0;
    int good_cnt = 0;
    int exp_err = 0;
    int last_err_cyc = -1000;
    bit after_strobe = 0;
    strobe_t last_s;
    strobe_t exp_q[$];
    int strobe_cyc[$];

    pio_stream_loader #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .action(action), .index(index), .mindex(mindex),
        .din(din), .err(err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest expected frame
    initial begin
        strobe_t s;
        forever begin
            @(negedge clk);
            if (reset) begin
                after_strobe = 0;
            end else begin
                if (after_strobe) begin
                    check("post_action_zero", action, 0);
                    check("post_ready", rx_ready, 1);
                    check("hold_index", index, last_s.i);
                    check("hold_mindex", mindex, last_s.m);
                    check("hold_din", din, last_s.d);
                    after_strobe = 0;
                end
                if (action != 0) begin
                    strobes++;
                    strobe_cyc.push_back(cyc);
                    check("ready_low_issue", rx_ready, 0);
                    check("err_excl", err, 0);
                    check("strobe_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        s = exp_q.pop_front();
                        check("strobe_action", action, s.a);
                        check("strobe_index", index, s.i);
                        check("strobe_mindex", mindex, s.m);
                        check("strobe_din", din, s.d);
                        last_s = s;
                        after_strobe = 1;
                    end
                end
                if (err) begin
                    errs++;
                    last_err_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic got;
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        do begin
            @(negedge clk);
            got = rx_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!got && n < 50);
        if (!got) check("accept_timeout", got, 1);
    endtask

    // Builds a frame from its fields, records what the loader must do with it, sends it
    task automatic send_frame(input logic [3:0] a, input logic [1:0] m, input logic [4:0] ix,
                              input logic [31:0] d, input logic [1:0] rsvd,
                              input int gap_max, input bit bad_csum);
        logic [7:0] b[7];
        logic [7:0] x;
        strobe_t s;
        int len;
        b[0] = {a, m, rsvd};
        b[1] = {3'b000, ix};
        b[2] = d[7:0];
        b[3] = d[15:8];
        b[4] = d[23:16];
        b[5] = d[31:24];
        x = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
        b[6] = bad_csum ? (x ^ 8'h01) : x;
        len = FRAME_LEN;
        if (bad_csum) begin
            exp_err++;
        end else begin
            s.a = a; s.i = ix; s.m = m; s.d = d;
            exp_q.push_back(s);
            good_cnt++;
        end
        for (int k = 0; k < len; k++) begin
            if (gap_max > 0) begin
                int g;
                g = $urandom_range(0, gap_max);
                if (g > 0) idle(g);
            end
            send_byte(b[k]);
        end
        rx_valid = 1'b0;
    endtask

    task automatic checkpoint(input string tag);
        idle(4);
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_errs"}, errs, exp_err);
        check({tag, "_frame_cnt"}, frame_cnt, good_cnt % (1 << CNT_W));
    endtask

    initial begin
        int s0, bad, t0, dl;
        logic [31:0] r, r2;

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_action", action, 0);
        check("rst_index", index, 0);
        check("rst_mindex", mindex, 0);
        check("rst_din", din, 0);
        check("rst_err", err, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_ready", rx_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        // Single instruction frame, continuous valid
        send_frame(4'd1, 2'd0, 5'd0, 32'h0000_1234, 2'd0, 0, 0);
        checkpoint("single");

        // 32 back-to-back instruction frames, index 0..31
        s0 = strobes;
        strobe_cyc.delete();
        for (int i = 0; i < 32; i++) begin
            send_frame(4'd1, 2'd0, 5'(i), 32'h1000_0000 + i, 2'd0, 0, 0);
        end
        checkpoint("b2b");
        check("b2b_strobes", strobes - s0, 32);
        bad = 0;
        for (int i = 1; i < strobe_cyc.size(); i++) begin
            if (strobe_cyc[i] - strobe_cyc[i-1] != FRAME_CYC) bad++;
        end
        check("b2b_spacing", bad, 0);

        // Zero action byte rejected, then a valid frame
        exp_err++;
        send_byte(8'h0C);
        send_frame(4'd2, 2'd3, 5'd3, 32'hDEAD_BEEF, 2'd0, 0, 0);
        checkpoint("resync");

        // Bad index byte, remaining stream parsed afresh
        exp_err++;
        send_byte(8'h10);
        send_byte(8'hE0);
        send_frame(4'd3, 2'd1, 5'd17, 32'hCAFE_0001, 2'd0, 0, 0);
        checkpoint("bad_idx");

        // Partial frame dropped by inter-byte timeout
        exp_err++;
        send_byte(8'h10);
        send_byte(8'h05);
        send_byte(8'hAA);
        t0 = cyc;
        idle(TIMEOUT + 4);
        dl = last_err_cyc - t0;
        check("timeout_latency", (dl >= TIMEOUT) && (dl <= TIMEOUT + 1), 1);
        check("timeout_no_strobe", exp_q.size(), 0);
        send_frame(4'd1, 2'd2, 5'd9, 32'h0BAD_F00D, 2'd0, 0, 0);
        checkpoint("timeout");

        // Reset in the middle of a frame
        send_byte(8'h10);
        send_byte(8'h00);
        send_byte(8'h34);
        send_byte(8'h12);
        rx_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_rst_action", action, 0);
        check("mid_rst_din", din, 0);
        check("mid_rst_index", index, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_frame_cnt", frame_cnt, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        good_cnt = 0;
        send_frame(4'd4, 2'd1, 5'd21, 32'h5566_7788, 2'd0, 0, 0);
        checkpoint("after_rst");

`ifdef PIO_LOADER_CSUM_EN
        // Checksum accepted then rejected
        send_frame(4'd1, 2'd0, 5'd0, 32'h0000_1234, 2'd0, 0, 0);
        send_frame(4'd1, 2'd0, 5'd0, 32'h0000_1234, 2'd0, 0, 1);
        checkpoint("csum");
`endif

        // Randomized mix of good and rejected frames with stalls
        for (int n = 0; n < 40; n++) begin
            r  = $urandom;
            r2 = $urandom;
            case ($urandom_range(0, 9))
                0: begin
                    exp_err++;
                    send_byte({4'h0, r[3:0]});
                end
                1: begin
                    exp_err++;
                    send_byte({(r[7:4] == 4'h0) ? 4'h5 : r[7:4], r[3:0]});
                    send_byte({3'($urandom_range(1, 7)), r[12:8]});
                end
`ifdef PIO_LOADER_CSUM_EN
                2: send_frame((r[3:0] == 0) ? 4'd1 : r[3:0], r[5:4], r[10:6], r2, r[12:11], 3, 1);
`endif
                default: send_frame((r[3:0] == 0) ? 4'd7 : r[3:0], r[5:4], r[10:6], r2, r[12:11], 3, 0);
            endcase
        end
        checkpoint("random");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
